fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of the instruction memory (imem) and downstream of nothing but the redirect path.
- Owns the PC, drives the imem word address, and captures the combinational imem read data.
- Queues {pc, inst} pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles redirects (branch/jump), decode backpressure and a halt condition.

---
 rtl/fetch_unit.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, addresses imem, queues {pc, inst} pairs for decode.
// Latency: an instruction pushed into an empty queue is on out_inst the next cycle.
// Backpressure: out_ready low with a full queue freezes pc and queue contents.
// Optional build macro FETCH_PERF_EN adds fetch_cnt / stall_cnt counters.
module fetch_unit #(
    parameter int          IMEM_ADDR_WIDTH = 10,
    parameter int          FQ_DEPTH        = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter logic [31:0] HALT_INST       = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]                imem_dout,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    output logic                       halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                fetch_cnt,
    output logic [31:0]                stall_cnt
`endif
);

    // Pointer width covers exactly FQ_DEPTH entries, so pointers wrap for free
    // (FQ_DEPTH is a power of two). Count needs one more state for "full".
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [31:0]    pc;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [31:0]    q_pc   [FQ_DEPTH];
    logic [31:0]    q_inst [FQ_DEPTH];

    logic           fetch_en;
    logic           fq_full;
    logic           push;
    logic           pop;
    logic           push_is_halt;
    logic [31:0]    redirect_tgt;

    // Redirect target is always word aligned; low two bits are dropped here.
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    // PCs beyond the imem range simply alias through the truncated address.
    assign imem_addr = pc[IMEM_ADDR_WIDTH+1:2];

    // Queue status and handshake. Redirect masks out_valid so decode never
    // completes a handshake on an entry that is being flushed this edge.
    assign fq_full   = (count == DEPTH_C);
    assign out_valid = (count != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;

    // A full queue still accepts a push when the head leaves on the same edge.
    assign push         = fetch_en & ~redirect_valid & (~fq_full | pop);
    assign push_is_halt = push & (imem_dout == HALT_INST);

    // Head of queue; holds stale data while empty.
    assign out_pc   = q_pc[rd_ptr];
    assign out_inst = q_inst[rd_ptr];

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: BOOT always leaves after one cycle (redirect or not),
    // RUN stops on enqueuing the halt word, HALT waits for a redirect.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN: begin
                if (push_is_halt) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect_valid) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    // FSM outputs: fetching is only enabled in RUN; halted mirrors HALT.
    always_comb begin
        fetch_en = 1'b0;
        halted   = 1'b0;
        unique case (state)
            ST_BOOT: begin
                fetch_en = 1'b0;
                halted   = 1'b0;
            end
            ST_RUN: begin
                fetch_en = 1'b1;
                halted   = 1'b0;
            end
            ST_HALT: begin
                fetch_en = 1'b0;
                halted   = 1'b1;
            end
            default: begin
                fetch_en = 1'b0;
                halted   = 1'b0;
            end
        endcase
    end

    // Program counter: redirect wins, otherwise advance by one word per push
    // (wrapping modulo 2^32); frozen whenever no push happens.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_tgt;
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; cleared on reset so the head outputs read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_inst[i] <= '0;
            end
        end else if (push) begin
            q_pc[wr_ptr]   <= pc;
            q_inst[wr_ptr] <= imem_dout;
        end
    end

`ifdef FETCH_PERF_EN
    logic run_stall;

    // A stall is a RUN cycle that neither pushes nor is being redirected.
    assign run_stall = fetch_en & ~push & ~redirect_valid;

    // Saturating fetch counter: one per push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
        end else if (push && (fetch_cnt != 32'hFFFF_FFFF)) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (run_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
